fir_stream_adapter: RTL and testbench
=====================================

# fir_stream_adapter

Upstream/downstream companion for the team's multi-cycle FIR filter. Accepts samples from a valid/ready stream, such as a codec or ADC front end. Drives the filter's one-cycle `input_ready` strobe with a held sample, waits for `output_ready`, and captures the result one cycle later. Results go into a small output FIFO presented as a valid/ready stream. The adapter guarantees the filter never sees a new strobe while busy.

## Interface
- `N`, 20, sample width; also the filter tap count.
- `FIFO_DEPTH`, 4, output FIFO entries, ≥2.
- `TIMEOUT`, 64, maximum WAIT cycles before abort; used only with the watchdog macro.

- `ck` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `s_data` input N: signed input sample.
- `s_valid` input 1: input sample valid.
- `s_ready` output 1: adapter can accept a sample.
- `f_in` output N: sample to filter, held stable from ISSUE through WAIT.
- `f_input_ready` output 1: one-cycle start strobe to filter.
- `f_out` input N: filter result, valid the cycle after `f_output_ready`.
- `f_output_ready` input 1: filter completion strobe.
- `m_data` output N: FIFO head, first-word-fall-through.
- `m_valid` output 1: FIFO non-empty.
- `m_ready` input 1: downstream pop.
- `busy` output 1: state ≠ IDLE.
- `timeout` output 1: sticky watchdog flag; constant 0 without the macro.

## Operation
- Reset values: state IDLE, FIFO empty, hold register 0.
  - `f_in`=0, `f_input_ready`=0, `m_valid`=0, `m_data`=0, `busy`=0, `timeout`=0.
  - `s_ready` forced 0 while `rst`=1.
- **IDLE:**
  - `s_ready` = (count < FIFO_DEPTH).
  - On `s_valid && s_ready`, latch `s_data` into the hold register → ISSUE.
- **ISSUE:**
  - `f_input_ready`=1 for exactly this cycle; `f_in`=hold.
  - → WAIT.
- **WAIT:**
  - `f_in`=hold.
  - On `f_output_ready`=1 → CAPTURE.
- **CAPTURE:**
  - Push `f_out` into the FIFO; → IDLE.
  - The space check in IDLE guarantees room, because only CAPTURE pushes.
- FIFO:
  - Circular buffer; count range 0..FIFO_DEPTH; read/write pointers wrap at FIFO_DEPTH (non-power-of-two allowed).
  - Pop when `m_valid && m_ready`.
  - Simultaneous push and pop: count unchanged, data order preserved.
  - Push and pop into an empty FIFO are not allowed in the same cycle (`m_valid` is 0 then); the pushed entry appears next cycle.
- `s_ready` is 0 in every state except IDLE; at most one sample in flight.
- A `f_output_ready` pulse seen outside WAIT is ignored.
- `rst` mid-operation: immediate return to IDLE; FIFO flushed; the in-flight sample is dropped. The filter shares `rst` and also returns to waiting.
- No arithmetic on sample data; values pass bit-exact.

## Timing
- Accept at cycle t (IDLE, handshake) → ISSUE at t+1.
- With the N=20 filter:
  - `f_output_ready` at t+1+N+2 = t+23.
  - CAPTURE at t+24.
  - `m_valid` at t+25.
- Next accept at t+25 earliest; throughput is one sample per N+5 cycles.
- `m_data`/`m_valid` are registered FIFO outputs; `s_ready` is combinational from state and count.

## Configuration
- `FIR_ADAPTER_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT and is cleared on entering WAIT.
  - If it reaches TIMEOUT without `f_output_ready`, `timeout` is set (sticky until `rst`), the sample is discarded with no FIFO push, and the state → IDLE.
- Undefined: no counter; WAIT is unbounded; `timeout` is tied 0; `TIMEOUT` is unused.

## Structure
- Package `fir_pkg` holds:
  - default N;
  - `sample_t` (signed [N-1:0]);
  - the adapter state enum {IDLE, ISSUE, WAIT, CAPTURE}.
- Sub-module `fir_adapter_fifo` (parameters N, FIFO_DEPTH): push/pop, count, `full`/`empty`.
- The adapter holds the FSM, hold register and watchdog.

## Test plan
- **Single sample, FIR N=20 attached:** `s_data`=1000 accepted at t.
  - `f_input_ready` high only at t+1.
  - `f_in`=1000 stable through t+23.
  - `m_valid` at t+25 with `m_data` = filter output.
- **Back-to-back with `s_valid` held high,** samples 1, 2, 3:
  - accepts are spaced 25 cycles apart;
  - exactly one strobe per sample;
  - outputs arrive in order.
- **`m_ready`=0:**
  - after 4 results, `s_ready`=0 in IDLE and no 5th strobe;
  - one pop restores `s_ready` the next cycle;
  - simultaneous push and pop keeps count stable.
- **Stub filter that never strobes, macro defined, TIMEOUT=64:**
  - `timeout`=1 after 64 WAIT cycles;
  - FIFO stays empty;
  - the adapter returns to IDLE and accepts again.
  - Without the macro the adapter stays in WAIT indefinitely.
- **`rst` pulse during WAIT with 2 results queued:**
  - all outputs reach reset values immediately;
  - `m_valid`=0;
  - no stale strobe after release.
- **Spurious `f_output_ready` in IDLE:** no FIFO push, state unchanged.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types for the FIR stream adapter.
// Default sample width, sample type and adapter FSM states.
package fir_pkg;

    localparam int N_DEFAULT = 20;

    typedef logic signed [N_DEFAULT-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE
    } adapter_state_t;

endpackage

// File: rtl/fir_adapter_fifo.sv
// Output FIFO for the FIR adapter: circular buffer, first-word-fall-through.
// Pointers wrap at FIFO_DEPTH, so non-power-of-two depths work.
module fir_adapter_fifo
    import fir_pkg::*;
#(
    parameter int N          = N_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           ck,
    input  logic                           rst,
    input  logic                           push,
    input  logic [N-1:0]                   push_data,
    input  logic                           pop,
    output logic [N-1:0]                   pop_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                           full,
    output logic                           empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    logic [N-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge ck) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping, flushed by reset.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_stream_adapter.sv
// Stream adapter around the multi-cycle FIR: one sample in flight, results queued.
// Optional WAIT watchdog enabled by defining FIR_ADAPTER_TIMEOUT_EN.
module fir_stream_adapter
    import fir_pkg::*;
#(
    parameter int N          = N_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [N-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [N-1:0] f_in,
    output logic         f_input_ready,
    input  logic [N-1:0] f_out,
    input  logic         f_output_ready,
    output logic [N-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         busy,
    output logic         timeout
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    adapter_state_t state;
    adapter_state_t state_nxt;
    logic [N-1:0]   hold;
    logic           accept;
    logic           wd_expire;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    // Only CAPTURE pushes, so checking space before accepting guarantees room.
    assign s_ready       = !rst && (state == IDLE) && !fifo_full;
    assign accept        = s_valid && s_ready;
    assign f_in          = hold;
    assign f_input_ready = (state == ISSUE);
    assign busy          = (state != IDLE);
    assign m_valid       = !fifo_empty;

`ifdef FIR_ADAPTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt;
    logic          timeout_q;

    assign wd_expire = (state == WAIT) && !f_output_ready
                       && (wd_cnt == TW'(TIMEOUT - 1));
    assign timeout   = timeout_q;

    // Watchdog: counts WAIT cycles from zero, flag sticks until reset.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if (state == WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    logic unused_cfg;
    assign unused_cfg = ^fifo_count;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^{fifo_count, TIMEOUT > 0};
`endif

    // State register.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold register keeps the sample stable for the filter.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (accept) begin
            hold <= s_data;
        end
    end

    // Next-state logic; stray completion strobes outside WAIT are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (f_output_ready) begin
                    state_nxt = CAPTURE;
                end else if (wd_expire) begin
                    state_nxt = IDLE;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    fir_adapter_fifo #(
        .N          (N),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ck        (ck),
        .rst       (rst),
        .push      (state == CAPTURE),
        .push_data (f_out),
        .pop       (m_ready),
        .pop_data  (m_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_fir_stream_adapter.sv
// Directed bench for fir_stream_adapter with a behavioural N=20 FIR stand-in.
// Stand-in result is f_in + 7, output_ready 22 cycles after the strobe.
module tb_fir_stream_adapter;

    localparam int N = 20;

    logic         ck = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [N-1:0] f_in;
    logic         f_input_ready;
    logic [N-1:0] f_out;
    logic         f_output_ready;
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         busy;
    logic         timeout;

    logic         stub = 1'b0;
    logic         spur = 1'b0;
    logic         fo_rdy;
    logic [4:0]   fcnt;
    logic [N-1:0] mdl_in;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0] din;
        logic [N-1:0] dout;
    } vec_t;

    always #5 ck = ~ck;

    fir_stream_adapter #(.N(N), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .ck             (ck),
        .rst            (rst),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .f_in           (f_in),
        .f_input_ready  (f_input_ready),
        .f_out          (f_out),
        .f_output_ready (f_output_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .busy           (busy),
        .timeout        (timeout)
    );

    assign f_output_ready = fo_rdy | spur;

    // Filter stand-in: strobe, 21-cycle countdown, ready pulse, result next cycle.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            fcnt   <= '0;
            fo_rdy <= 1'b0;
            mdl_in <= '0;
            f_out  <= '0;
        end else begin
            fo_rdy <= 1'b0;
            f_out  <= fo_rdy ? mdl_in + 20'd7 : 20'h5A5A5;
            if (f_input_ready && !stub) begin
                fcnt   <= 5'd21;
                mdl_in <= f_in;
            end else if (fcnt != 0) begin
                fcnt <= fcnt - 1'b1;
                if (fcnt == 5'd1) begin
                    fo_rdy <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic send(input logic [N-1:0] v);
        int i;
        s_valid = 1'b1;
        s_data  = v;
        for (i = 0; i < 200 && !s_ready; i++) step();
        chk("send_ready", {31'd0, s_ready}, 32'd1);
        step();
        s_valid = 1'b0;
        for (i = 0; i < 200 && busy; i++) step();
        chk("send_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic pop_one(input string name, input logic [N-1:0] exp);
        chk({name, "_valid"}, {31'd0, m_valid}, 32'd1);
        chk({name, "_data"}, {12'd0, m_data}, {12'd0, exp});
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic wait_fo();
        int i;
        for (i = 0; i < 200 && !fo_rdy; i++) step();
        chk("fo_seen", {31'd0, fo_rdy}, 32'd1);
    endtask

    initial begin
        vec_t vt [5];
        int acc [3];
        logic [N-1:0] outs [4];
        int n;
        int k;
        int strobes;
        int bad;

        vt[0] = '{din: 20'd0,     dout: 20'h00007};
        vt[1] = '{din: 20'hFFFFF, dout: 20'h00006};
        vt[2] = '{din: 20'h7FFFF, dout: 20'h80006};
        vt[3] = '{din: 20'h80000, dout: 20'h80007};
        vt[4] = '{din: 20'h12345, dout: 20'h1234C};

        // reset state
        #12;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_f_in", {12'd0, f_in}, 32'd0);
        chk("rst_strobe", {31'd0, f_input_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {12'd0, m_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("idle_s_ready", {31'd0, s_ready}, 32'd1);

        // single sample with cycle-exact timing
        s_valid = 1'b1;
        s_data  = 20'd1000;
        chk("t0_ready", {31'd0, s_ready}, 32'd1);
        step();
        s_valid = 1'b0;
        chk("t1_strobe", {31'd0, f_input_ready}, 32'd1);
        chk("t1_f_in", {12'd0, f_in}, 32'd1000);
        chk("t1_s_ready", {31'd0, s_ready}, 32'd0);
        strobes = 0;
        bad = 0;
        for (int c = 2; c <= 23; c++) begin
            step();
            if (f_input_ready) strobes++;
            if (f_in !== 20'd1000) bad++;
        end
        chk("t2_23_strobes", strobes, 0);
        chk("t2_23_f_in_unstable", bad, 0);
        step();
        chk("t24_m_valid", {31'd0, m_valid}, 32'd0);
        step();
        chk("t25_busy", {31'd0, busy}, 32'd0);
        chk("t25_s_ready", {31'd0, s_ready}, 32'd1);
        pop_one("t25", 20'd1007);
        chk("t26_m_valid", {31'd0, m_valid}, 32'd0);

        // table: bit-exact pass-through of boundary values
        for (int i = 0; i < 5; i++) begin
            send(vt[i].din);
            pop_one($sformatf("vec%0d", i), vt[i].dout);
        end

        // back-to-back with s_valid held
        s_valid = 1'b1;
        s_data  = 20'd1;
        m_ready = 1'b1;
        n = 0;
        k = 0;
        strobes = 0;
        for (int c = 0; c < 90; c++) begin
            if (s_valid && s_ready) begin
                acc[n] = c;
                n++;
            end
            if (f_input_ready) strobes++;
            if (m_valid && m_ready && k < 4) begin
                outs[k] = m_data;
                k++;
            end
            step();
            s_valid = (n < 3);
            s_data  = N'(n + 1);
        end
        m_ready = 1'b0;
        chk("b2b_accepts", n, 3);
        chk("b2b_gap1", acc[1] - acc[0], 25);
        chk("b2b_gap2", acc[2] - acc[1], 25);
        chk("b2b_strobes", strobes, 3);
        chk("b2b_outputs", k, 3);
        chk("b2b_out0", {12'd0, outs[0]}, 32'd8);
        chk("b2b_out1", {12'd0, outs[1]}, 32'd9);
        chk("b2b_out2", {12'd0, outs[2]}, 32'd10);

        // full FIFO blocks further accepts
        for (int i = 0; i < 4; i++) send(20'h100 + N'(i));
        chk("full_s_ready", {31'd0, s_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd0);
        s_valid = 1'b1;
        s_data  = 20'h104;
        strobes = 0;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            if (f_input_ready) strobes++;
            if (s_ready) bad++;
            step();
        end
        chk("full_no_strobe", strobes, 0);
        chk("full_no_ready", bad, 0);
        pop_one("full_pop", 20'h107);
        chk("pop_restores_ready", {31'd0, s_ready}, 32'd1);
        step();
        s_valid = 1'b0;
        wait_fo();
        step();
        chk("cap_busy", {31'd0, busy}, 32'd1);
        pop_one("cap_pop", 20'h108);
        chk("cap_s_ready", {31'd0, s_ready}, 32'd1);
        pop_one("drain0", 20'h109);
        pop_one("drain1", 20'h10A);
        pop_one("drain2", 20'h10B);
        chk("drain_empty", {31'd0, m_valid}, 32'd0);

        // spurious completion strobe in IDLE
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        step();
        chk("spur_m_valid", {31'd0, m_valid}, 32'd0);
        chk("spur_busy", {31'd0, busy}, 32'd0);
        chk("spur_s_ready", {31'd0, s_ready}, 32'd1);

        // filter that never completes
        stub = 1'b1;
        s_valid = 1'b1;
        s_data  = 20'd55;
        chk("stub_ready", {31'd0, s_ready}, 32'd1);
        step();
        s_valid = 1'b0;
        step();
`ifdef FIR_ADAPTER_TIMEOUT_EN
        for (int c = 1; c < 64; c++) step();
        chk("wd64_busy", {31'd0, busy}, 32'd1);
        chk("wd64_timeout", {31'd0, timeout}, 32'd0);
        step();
        chk("wd_timeout", {31'd0, timeout}, 32'd1);
        chk("wd_busy", {31'd0, busy}, 32'd0);
        chk("wd_s_ready", {31'd0, s_ready}, 32'd1);
        chk("wd_m_valid", {31'd0, m_valid}, 32'd0);
        stub = 1'b0;
        send(20'h00123);
        pop_one("wd_after", 20'h0012A);
        chk("wd_sticky", {31'd0, timeout}, 32'd1);
`else
        for (int c = 0; c < 200; c++) step();
        chk("nowd_busy", {31'd0, busy}, 32'd1);
        chk("nowd_timeout", {31'd0, timeout}, 32'd0);
        chk("nowd_s_ready", {31'd0, s_ready}, 32'd0);
        chk("nowd_m_valid", {31'd0, m_valid}, 32'd0);
        stub = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif

        // reset during WAIT with two results queued
        send(20'h200);
        send(20'h201);
        s_valid = 1'b1;
        s_data  = 20'h202;
        step();
        s_valid = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_m_valid", {31'd0, m_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("mid_rst_f_in", {12'd0, f_in}, 32'd0);
        chk("mid_rst_strobe", {31'd0, f_input_ready}, 32'd0);
        chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_m_data", {12'd0, m_data}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
        step();
        rst = 1'b0;
        strobes = 0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (f_input_ready) strobes++;
            if (m_valid || busy) bad++;
            step();
        end
        chk("post_rst_strobes", strobes, 0);
        chk("post_rst_activity", bad, 0);
        send(20'h300);
        pop_one("post_rst", 20'h307);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule
